ex_madd_msub: RTL and testbench
===============================

# ex_madd_msub

Sequential multiply-accumulate engine for the EX stage. It executes MADD, MADDU, MSUB and MSUBU as a 4-step iterative 32x32 multiply followed by a HI/LO accumulate. It produces the `hilo_o`/`cnt_o` temporaries that ex_mem holds during a stall and returns as `hilo_i`/`cnt_i`, so it is the EX-side partner of that feedback path. While busy it raises `stallreq_o` toward ctrl, and on completion it drives the final HI/LO write into the EX outputs.

## Interface
- No parameters; widths from defines.v (`RegDataBus` 32, `DoubleRegDataBus` 64, `AluOpBus` 8).
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset (`RstEnable` = 1'b1).
- aluop_i  in  8  EX alu opcode; active ops are `EXE_MADD_OP`, `EXE_MADDU_OP`, `EXE_MSUB_OP`, `EXE_MSUBU_OP`.
- reg1_i  in  32  multiplicand (rs).
- reg2_i  in  32  multiplier (rt).
- hi_i, lo_i  in  32 each  current HI/LO after forwarding.
- hilo_i  in  64  temporary returned by ex_mem.
- cnt_i  in  2  phase returned by ex_mem.
- hilo_o  out  64  temporary sent to ex_mem.
- cnt_o  out  2  phase sent to ex_mem: 00 none, 01 product valid, 10 result valid.
- stallreq_o  out  1  stall request to ctrl.
- whilo_o  out  1  HI/LO write enable.
- hi_o, lo_o  out  32 each  HI/LO write data.

## Operation
- States: IDLE, MUL (4 steps, step counter 0..3), ACC, DONE.
- IDLE, non-MAC op: all outputs 0.
- IDLE, MAC op, cnt_i=00:
  - Latch operands: unsigned ops take raw values; signed ops take the absolute values of reg1_i/reg2_i and record neg = reg1_i[31]^reg2_i[31].
  - Clear the 64-bit accumulator.
  - stallreq_o=1; go to MUL.
- IDLE, MAC op, cnt_i=10:
  - The result was already computed and ex_mem held it; no restart.
  - whilo_o=1, {hi_o,lo_o}=hilo_i, stallreq_o=0, hilo_o=hilo_i, cnt_o=10.
- IDLE, MAC op, cnt_i=01: treat as cnt_i=00 (restart).
- MUL step k:
  - acc += (a * b[7:0]) << (8k), using the 32x8 partial product; b >>= 8.
  - stallreq_o=1, cnt_o=00.
  - After k=3 go to ACC.
- ACC:
  - P = neg ? -acc : acc, mod 2^64.
  - hilo_o=P, cnt_o=01, stallreq_o=1; go to DONE.
- DONE:
  - If cnt_i≠01: keep stallreq_o=1, cnt_o=01, hilo_o=P, and stay in DONE.
  - Else: R = {hi_i,lo_i} + hilo_i (MADD/MADDU) or {hi_i,lo_i} - hilo_i (MSUB/MSUBU), mod 2^64.
  - whilo_o=1, {hi_o,lo_o}=R, hilo_o=R, cnt_o=10, stallreq_o=0; go to IDLE next edge.
- Operand or opcode changes after latch are ignored until IDLE.
- Reset:
  - Registered state goes to IDLE; step counter, accumulator, latched operands and neg all go to 0.
  - Mid-operation reset abandons the instruction with no HI/LO write.
  - All outputs are combinational from state and inputs, and are 0 in IDLE with a non-MAC op or while rst is asserted.

## Timing
- Instruction present in EX at cycle T with cnt_i=00:
  - stallreq_o=1 in cycles T..T+5.
  - MUL occupies T+1..T+4.
  - ACC at T+5: cnt_o=01.
  - ex_mem holds the temporary, so cnt_i=01 at T+6.
- DONE at T+6: whilo_o=1 and result valid, stallreq_o=0; the instruction advances on the T+6 edge.
- Latency: 7 EX cycles per MAC, with 6 stall cycles.
- Back-to-back MACs: the second is seen in IDLE at T+7 with cnt_i=00, because ex_mem clears cnt on advance; it starts normally.
- stallreq_o depends combinationally on aluop_i only in IDLE; elsewhere it comes from state.

## Test plan
- MADD reg1=3, reg2=4, HI/LO=0x00000000_0000000A:
  - stallreq_o high T..T+5; cnt_o=01 with hilo_o=0xC at T+5.
  - At T+6: whilo_o=1, hi_o=0, lo_o=0x16.
- MSUB reg1=0xFFFFFFFF, reg2=2, HI/LO=0: P=0xFFFFFFFF_FFFFFFFE; result hi_o=0, lo_o=2.
- MADDU reg1=reg2=0xFFFFFFFF, HI/LO=0x00000000_00000001: result 0xFFFFFFFE_00000002.
- MSUBU 1*1, HI/LO=0: result wraps to hi_o=lo_o=0xFFFFFFFF.
- rst at T+3 (mid-MUL):
  - Next cycle all outputs 0, stallreq_o=0, no HI/LO write.
  - Re-issuing MADD 3*4 then completes per the first scenario.
- IDLE checks:
  - MAC op with cnt_i=10, hilo_i=0x12345678_9ABCDEF0: no stall; whilo_o=1, hi_o=0x12345678, lo_o=0x9ABCDEF0.
  - Non-MAC op: all outputs 0.
  - In DONE with cnt_i held at 00: stall persists until cnt_i=01.

Source files
------------

// File: rtl/ex_madd_msub.sv
// Iterative MADD/MADDU/MSUB/MSUBU engine for the EX stage: a 4-step 32x8 multiply,
// then a HI/LO accumulate, with the product parked in ex_mem across the stall.
module ex_madd_msub (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic [63:0] hilo_i,
  input  logic [1:0]  cnt_i,
  output logic [63:0] hilo_o,
  output logic [1:0]  cnt_o,
  output logic        stallreq_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [7:0] EXE_MADD_OP  = 8'b1010_0110;
  localparam logic [7:0] EXE_MADDU_OP = 8'b1010_1000;
  localparam logic [7:0] EXE_MSUB_OP  = 8'b1010_1010;
  localparam logic [7:0] EXE_MSUBU_OP = 8'b1010_1011;

  localparam logic [1:0] CNT_NONE = 2'b00;
  localparam logic [1:0] CNT_PROD = 2'b01;
  localparam logic [1:0] CNT_RES  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ACC, S_DONE} state_t;

  state_t      state, state_next;
  logic [1:0]  step;
  logic [63:0] acc;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        neg;
  logic        sub;

  logic        is_signed_op;
  logic        is_sub_op;
  logic        is_mac;
  logic        start;
  logic [31:0] reg1_abs;
  logic [31:0] reg2_abs;
  logic [39:0] partial;
  logic [63:0] partial_shifted;
  logic [63:0] product;
  logic [63:0] result;

  assign is_signed_op = (aluop_i == EXE_MADD_OP) || (aluop_i == EXE_MSUB_OP);
  assign is_sub_op    = (aluop_i == EXE_MSUB_OP) || (aluop_i == EXE_MSUBU_OP);
  assign is_mac       = is_signed_op || (aluop_i == EXE_MADDU_OP) || (aluop_i == EXE_MSUBU_OP);
  // A held result (cnt_i=10) must not restart; a stale product (01) in IDLE does.
  assign start        = (state == S_IDLE) && is_mac && (cnt_i != CNT_RES);

  assign reg1_abs = (is_signed_op && reg1_i[31]) ? -reg1_i : reg1_i;
  assign reg2_abs = (is_signed_op && reg2_i[31]) ? -reg2_i : reg2_i;

  assign partial         = {8'b0, op_a} * {32'b0, op_b[7:0]};
  assign partial_shifted = {24'b0, partial} << {step, 3'b000};
  assign product         = neg ? -acc : acc;
  assign result          = sub ? ({hi_i, lo_i} - hilo_i) : ({hi_i, lo_i} + hilo_i);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step <= 2'd0;
      acc  <= 64'd0;
      op_a <= 32'd0;
      op_b <= 32'd0;
      neg  <= 1'b0;
      sub  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_a <= reg1_abs;
            op_b <= reg2_abs;
            neg  <= is_signed_op && (reg1_i[31] ^ reg2_i[31]);
            sub  <= is_sub_op;
            acc  <= 64'd0;
            step <= 2'd0;
          end
        end
        S_MUL: begin
          acc  <= acc + partial_shifted;
          op_b <= op_b >> 8;
          step <= step + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every combinational output gets a default before the case, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_MUL;
      S_MUL:  if (step == 2'd3) state_next = S_ACC;
      S_ACC:  state_next = S_DONE;
      S_DONE: if (cnt_i == CNT_PROD) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    stallreq_o = 1'b0;
    whilo_o    = 1'b0;
    hi_o       = 32'd0;
    lo_o       = 32'd0;
    hilo_o     = 64'd0;
    cnt_o      = CNT_NONE;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          if (is_mac) begin
            if (cnt_i == CNT_RES) begin
              whilo_o      = 1'b1;
              {hi_o, lo_o} = hilo_i;
              hilo_o       = hilo_i;
              cnt_o        = CNT_RES;
            end else begin
              stallreq_o = 1'b1;
            end
          end
        end
        S_MUL: stallreq_o = 1'b1;
        S_ACC: begin
          stallreq_o = 1'b1;
          hilo_o     = product;
          cnt_o      = CNT_PROD;
        end
        S_DONE: begin
          if (cnt_i != CNT_PROD) begin
            stallreq_o = 1'b1;
            hilo_o     = product;
            cnt_o      = CNT_PROD;
          end else begin
            whilo_o      = 1'b1;
            {hi_o, lo_o} = result;
            hilo_o       = result;
            cnt_o        = CNT_RES;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_madd_msub.sv
// Directed bench for ex_madd_msub: stimulus queues the expected outputs of each cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_ex_madd_msub;

  localparam logic [7:0] OP_MADD  = 8'hA6;
  localparam logic [7:0] OP_MADDU = 8'hA8;
  localparam logic [7:0] OP_MSUB  = 8'hAA;
  localparam logic [7:0] OP_MSUBU = 8'hAB;
  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_ADD   = 8'h20;

  typedef struct packed {
    logic        stall;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop;
  logic [31:0] reg1, reg2, hi_in, lo_in;
  logic [63:0] hilo_in;
  logic [1:0]  cnt_in;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;
  logic        stallreq_o, whilo_o;
  logic [31:0] hi_o, lo_o;

  obs_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  ex_madd_msub dut (
    .clk(clk), .rst(rst), .aluop_i(aluop), .reg1_i(reg1), .reg2_i(reg2),
    .hi_i(hi_in), .lo_i(lo_in), .hilo_i(hilo_in), .cnt_i(cnt_in),
    .hilo_o(hilo_o), .cnt_o(cnt_o), .stallreq_o(stallreq_o), .whilo_o(whilo_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  // Drive one EX cycle and queue what the DUT must show during it.
  task automatic cycle(input logic r, input logic [7:0] op, input logic [31:0] a, b, h, l,
                       input logic [63:0] hl, input logic [1:0] c,
                       input logic e_stall, e_whilo, input logic [63:0] e_hilo,
                       input logic [1:0] e_cnt, input string nm);
    obs_t e;
    @(posedge clk); #1;
    rst = r; aluop = op; reg1 = a; reg2 = b; hi_in = h; lo_in = l; hilo_in = hl; cnt_in = c;
    e = {e_stall, e_whilo, (e_whilo ? e_hilo : 64'h0), e_hilo, e_cnt};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Full MAC: start, 4 MUL steps (operands/opcode scrambled), ACC, optional DONE waits,
  // then ex_mem returns cnt=01 with the product.
  task automatic run_mac(input logic [7:0] op, input logic [31:0] r1, r2, h, l,
                         input logic [63:0] p, res, input int waits,
                         input logic [1:0] start_cnt, input logic [63:0] start_hilo,
                         input string nm);
    cycle(0, op, r1, r2, h, l, start_hilo, start_cnt, 1, 0, 64'h0, 2'b00, {nm, ":start"});
    for (int k = 0; k < 4; k++)
      cycle(0, OP_ADD, ~r1, ~r2, h, l, 64'h0, 2'b00, 1, 0, 64'h0, 2'b00, {nm, ":mul"});
    cycle(0, op, r1, r2, h, l, 64'h0, 2'b00, 1, 0, p, 2'b01, {nm, ":acc"});
    for (int w = 0; w < waits; w++)
      cycle(0, op, r1, r2, h, l, 64'h0, 2'b00, 1, 0, p, 2'b01, {nm, ":done_wait"});
    cycle(0, op, r1, r2, h, l, p, 2'b01, 0, 1, res, 2'b10, {nm, ":done"});
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t  e, a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {stallreq_o, whilo_o, hi_o, lo_o, hilo_o, cnt_o};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got stall=%b whilo=%b hi=%h lo=%h hilo=%h cnt=%b, expected stall=%b whilo=%b hi=%h lo=%h hilo=%h cnt=%b",
                 n, a.stall, a.whilo, a.hi, a.lo, a.hilo, a.cnt,
                 e.stall, e.whilo, e.hi, e.lo, e.hilo, e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; aluop = OP_MADD; reg1 = 32'd3; reg2 = 32'd4;
    hi_in = 32'd0; lo_in = 32'd0; hilo_in = 64'd0; cnt_in = 2'b00;

    // Outputs forced to zero while rst is held, even with a MAC op present.
    cycle(1, OP_MADD, 3, 4, 0, 0, 64'h0, 2'b00, 0, 0, 64'h0, 2'b00, "reset0");
    cycle(1, OP_MADD, 3, 4, 0, 0, 64'h0, 2'b10, 0, 0, 64'h0, 2'b00, "reset1");

    // IDLE behaviour.
    cycle(0, OP_NOP, 5, 6, 0, 0, 64'hFFFF_0000_FFFF_0000, 2'b10, 0, 0, 64'h0, 2'b00, "nonmac_cnt10");
    cycle(0, OP_ADD, 5, 6, 0, 0, 64'h1, 2'b01, 0, 0, 64'h0, 2'b00, "nonmac_cnt01");
    cycle(0, OP_MADD, 1, 1, 0, 0, 64'h12345678_9ABCDEF0, 2'b10, 0, 1, 64'h12345678_9ABCDEF0, 2'b10, "idle_cnt10");
    cycle(0, OP_NOP, 0, 0, 0, 0, 64'h0, 2'b00, 0, 0, 64'h0, 2'b00, "idle_nop");

    // Main scenarios; these run back to back with no gap.
    run_mac(OP_MADD,  32'd3, 32'd4, 32'h0, 32'hA, 64'hC, 64'h16, 0, 2'b00, 64'h0, "madd_3x4");
    run_mac(OP_MSUB,  32'hFFFFFFFF, 32'd2, 32'h0, 32'h0,
            64'hFFFFFFFF_FFFFFFFE, 64'h2, 0, 2'b00, 64'h0, "msub_m1x2");
    run_mac(OP_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1,
            64'hFFFFFFFE_00000001, 64'hFFFFFFFE_00000002, 0, 2'b00, 64'h0, "maddu_max");
    run_mac(OP_MSUBU, 32'd1, 32'd1, 32'h0, 32'h0,
            64'h1, 64'hFFFFFFFF_FFFFFFFF, 0, 2'b00, 64'h0, "msubu_wrap");
    run_mac(OP_MADD,  32'h80000000, 32'h80000000, 32'h0, 32'h0,
            64'h40000000_00000000, 64'h40000000_00000000, 0, 2'b00, 64'h0, "madd_minint");
    run_mac(OP_MSUB,  32'hFFFFFFFD, 32'd5, 32'h1, 32'h0,
            64'hFFFFFFFF_FFFFFFF1, 64'h00000001_0000000F, 0, 2'b00, 64'h0, "msub_m3x5");
    run_mac(OP_MADDU, 32'h12345678, 32'h01010101, 32'h0, 32'h0,
            64'h0012469D_1502CE78, 64'h0012469D_1502CE78, 0, 2'b00, 64'h0, "maddu_bytes");

    // DONE holds with cnt_i=00 until ex_mem returns 01.
    run_mac(OP_MADD, 32'd3, 32'd4, 32'h0, 32'hA, 64'hC, 64'h16, 3, 2'b00, 64'h0, "done_hold");

    // A stale product in IDLE (cnt_i=01) restarts the operation.
    run_mac(OP_MADD, 32'd3, 32'd4, 32'h0, 32'hA, 64'hC, 64'h16, 0, 2'b01, 64'hDEAD_BEEF, "idle_cnt01");

    // Reset in the middle of MUL abandons the instruction.
    cycle(0, OP_MADD, 3, 4, 0, 32'hA, 64'h0, 2'b00, 1, 0, 64'h0, 2'b00, "rst_mid:start");
    cycle(0, OP_MADD, 3, 4, 0, 32'hA, 64'h0, 2'b00, 1, 0, 64'h0, 2'b00, "rst_mid:mul0");
    cycle(0, OP_MADD, 3, 4, 0, 32'hA, 64'h0, 2'b00, 1, 0, 64'h0, 2'b00, "rst_mid:mul1");
    cycle(1, OP_MADD, 3, 4, 0, 32'hA, 64'h0, 2'b00, 0, 0, 64'h0, 2'b00, "rst_mid:assert");
    cycle(0, OP_NOP, 3, 4, 0, 32'hA, 64'h0, 2'b01, 0, 0, 64'h0, 2'b00, "rst_mid:after");
    cycle(0, OP_NOP, 3, 4, 0, 32'hA, 64'h0, 2'b00, 0, 0, 64'h0, 2'b00, "rst_mid:idle");
    run_mac(OP_MADD, 32'd3, 32'd4, 32'h0, 32'hA, 64'hC, 64'h16, 0, 2'b00, 64'h0, "rst_mid:reissue");
    cycle(0, OP_NOP, 0, 0, 0, 0, 64'h0, 2'b00, 0, 0, 64'h0, 2'b00, "final_idle");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
    end
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
